uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Parametrised UART receive controller: a single block with its own prescale edge counter, bit counter, 3-sample majority-vote sampler, deserialiser and frame checker. It converts the asynchronous `Rx_in` line into a `DATA_WIDTH`-bit word with a one-cycle `Data_Valid` strobe and per-frame error strobes. It supports run-time selection of parity enable and type, and of one or two stop bits. It sits between the RX pin synchroniser and the register/FIFO layer and replaces the separate FSM, edge-counter and checker blocks of the first-generation receiver.

## Interface
- `DATA_WIDTH`, 8, data bits per frame, legal 5..9
- `PRESCALE_W`, 6, width of `Prescale`
- `Clk` input 1 system clock, oversampling rate = `Prescale` × baud
- `Rst` input 1 reset, asynchronous, active-low
- `Rx_in` input 1 serial line, already synchronised, idle high
- `Prescale` input `PRESCALE_W` clocks per bit; values <4 treated as 4
- `Parity_En` input 1 1 = parity bit present
- `Parity_Type` input 1 0 = even, 1 = odd
- `Stop_Bits` input 1 0 = one stop bit, 1 = two
- `P_DATA` output `DATA_WIDTH` last good word, LSB received first
- `Data_Valid` output 1 one-cycle strobe, `P_DATA` updated
- `Parity_err` output 1 one-cycle strobe
- `Stop_err` output 1 one-cycle strobe
- `Start_err` output 1 one-cycle strobe, start bit rejected
- `Busy` output 1 high in every state except IDLE

## Operation
- Config (`Prescale`, `Parity_En`, `Parity_Type`, `Stop_Bits`) is latched on the IDLE→START transition. Mid-frame changes are ignored.
- P = latched prescale; mid = P>>1. The edge counter runs 0..P-1 in all non-IDLE/DONE states and wraps to 0 at P-1, with the bit counter incrementing on the wrap.
- `Rx_in` is sampled at edges mid-1, mid and mid+1. The bit value is the 2-of-3 majority, valid from edge mid+2.
- States: IDLE, START, DATA, PARITY, STOP, DONE. Unused encodings go to IDLE.
  - IDLE: `Rx_in`=0 → START with edge_cnt=0.
  - START: at edge P-1, majority=1 → `Start_err` pulse and go to IDLE; otherwise go to DATA.
  - DATA: shifts the majority bit in LSB-first. At edge P-1 of bit `DATA_WIDTH`, go to PARITY if `Parity_En`, else STOP.
  - PARITY: computes the expected value as the XOR of the data bits, XOR `Parity_Type`; a mismatch sets the pending parity error. At edge P-1, go to STOP.
  - STOP: every stop sample must be 1, else the pending stop error is set. With two stop bits, the first bit runs the full P. The final stop bit ends early at edge mid+2 → DONE, which leaves slack for back-to-back frames.
  - DONE (exactly one cycle):
    - With no pending error: load `P_DATA` and pulse `Data_Valid`. With a pending error: pulse `Parity_err` and/or `Stop_err` instead, and hold `P_DATA`.
    - Next state is START if `Rx_in`=0, else IDLE.
- `Parity_err` never asserts when `Parity_En`=0. Pending errors clear on entry to START.
- Reset mid-frame aborts immediately and discards the partial word.

## Timing
- Reset values:
  - `P_DATA`=0.
  - `Data_Valid`, `Parity_err`, `Stop_err`, `Start_err`, `Busy` all 0.
  - State = IDLE; counters = 0.
- All outputs are registered. `Busy` rises in the cycle START is entered.
- Cycle 0 = first START cycle. The DONE cycle, and therefore the strobes, falls at cycle F·P + mid + 3, where F = 1 + `DATA_WIDTH` + `Parity_En` + `Stop_Bits`.
  - Example: 8N1, P=8 → cycle 79.
- `Start_err` pulses in the first IDLE cycle after rejection, at cycle P.
- Each strobe is high for exactly one clock. `Data_Valid` and the error strobes are mutually exclusive.
- Back-to-back case: when `Rx_in` is low in DONE, the next START's cycle 0 is the cycle after DONE.

## Test plan
- 8N1, P=8, send 0xA5 → `Data_Valid` at cycle 79, `P_DATA`=0xA5, no errors.
- 8E1, P=16, send 0x3C with parity bit 1 (wrong) → `Parity_err` pulse, no `Data_Valid`, `P_DATA` holds its previous value.
- `DATA_WIDTH`=7, odd parity, two stop bits, P=8, send 0x55 with the second stop bit 0 → `Stop_err` pulse only.
- `Rx_in` low for 3 clocks only, P=8 → `Start_err` at cycle 8, return to IDLE, `Busy` low.
- Two 8N1 frames 0x12 and 0xEF with zero idle gap → two `Data_Valid` strobes with the correct data each. Also change `Prescale` mid-frame → no effect until the next frame.
- Assert `Rst` during the DATA state → all outputs 0 at once. A following clean frame of 0x81 → `Data_Valid` with `P_DATA`=0x81.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: prescaled bit timing, 3-sample majority vote,
// LSB-first deserialiser and parity/stop/start frame checking.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Rx_in,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  Parity_En,
   input  logic                  Parity_Type,
   input  logic                  Stop_Bits,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Parity_err,
   output logic                  Stop_err,
   output logic                  Start_err,
   output logic                  Busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [PRESCALE_W-1:0] PRESCALE_MIN = PRESCALE_W'(4);
   localparam logic [3:0]            LAST_BIT     = 4'(DATA_WIDTH - 1);

   state_t                  state, state_d;
   logic [PRESCALE_W-1:0]   edge_cnt, edge_d;
   logic [3:0]              bit_cnt, bit_d;
   logic [PRESCALE_W-1:0]   pres_q;
   logic                    par_en_q, par_type_q, stop2_q;
   logic [2:0]              samp;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic                    pend_par, pend_stop;

   logic [PRESCALE_W-1:0]   mid, last_edge, stop_end;
   logic                    active, edge_wrap, maj;
   logic                    start_frame, start_rej, shift_en, par_chk, stop_chk, frame_end;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign mid       = pres_q >> 1;
   assign last_edge = pres_q - PRESCALE_W'(1);
   // At the minimum prescale mid+2 falls past the bit, so the last stop bit ends at its final edge.
   assign stop_end  = ((mid + PRESCALE_W'(2)) > last_edge) ? last_edge : (mid + PRESCALE_W'(2));
   assign active    = state inside {S_START, S_DATA, S_PARITY, S_STOP};
   assign edge_wrap = active && (edge_cnt == last_edge);

   // The third sample is still in flight at edge mid+1, so use the live line value there.
   assign maj = (edge_cnt == (mid + PRESCALE_W'(1))) ? maj3(samp[0], samp[1], Rx_in)
                                                     : maj3(samp[0], samp[1], samp[2]);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_d;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      state_d     = state;
      start_frame = 1'b0;
      start_rej   = 1'b0;
      shift_en    = 1'b0;
      par_chk     = 1'b0;
      stop_chk    = 1'b0;
      frame_end   = 1'b0;

      case (state)
         S_IDLE: begin
            if (!Rx_in) begin
               state_d     = S_START;
               start_frame = 1'b1;
            end
         end
         S_START: begin
            if (edge_wrap) begin
               if (maj) begin
                  state_d   = S_IDLE;
                  start_rej = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (edge_wrap) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (edge_wrap) begin
               par_chk = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (stop2_q && (bit_cnt == 4'd0)) begin
               if (edge_wrap) stop_chk = 1'b1;
            end else if (edge_cnt == stop_end) begin
               stop_chk  = 1'b1;
               frame_end = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (!Rx_in) begin
               state_d     = S_START;
               start_frame = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!active || (state_d inside {S_IDLE, S_DONE}) || edge_wrap) edge_d = '0;
      else                                                           edge_d = edge_cnt + PRESCALE_W'(1);

      // The bit counter restarts on every state change, so it doubles as the stop-bit index.
      if (state_d != state) bit_d = '0;
      else if (edge_wrap)   bit_d = bit_cnt + 4'd1;
      else                  bit_d = bit_cnt;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         pres_q      <= PRESCALE_MIN;
         par_en_q    <= 1'b0;
         par_type_q  <= 1'b0;
         stop2_q     <= 1'b0;
         samp        <= '0;
         shift_q     <= '0;
         pend_par    <= 1'b0;
         pend_stop   <= 1'b0;
         P_DATA      <= '0;
         Data_Valid  <= 1'b0;
         Parity_err  <= 1'b0;
         Stop_err    <= 1'b0;
         Start_err   <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         Parity_err <= 1'b0;
         Stop_err   <= 1'b0;
         Start_err  <= 1'b0;
         Busy       <= (state_d != S_IDLE);
         edge_cnt   <= edge_d;
         bit_cnt    <= bit_d;

         if (start_frame) begin
            pres_q     <= (Prescale < PRESCALE_MIN) ? PRESCALE_MIN : Prescale;
            par_en_q   <= Parity_En;
            par_type_q <= Parity_Type;
            stop2_q    <= Stop_Bits;
            pend_par   <= 1'b0;
            pend_stop  <= 1'b0;
         end

         if (active) begin
            if (edge_cnt == (mid - PRESCALE_W'(1))) samp[0] <= Rx_in;
            if (edge_cnt == mid)                    samp[1] <= Rx_in;
            if (edge_cnt == (mid + PRESCALE_W'(1))) samp[2] <= Rx_in;
         end

         if (shift_en) shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};

         if (par_chk && (maj != ((^shift_q) ^ par_type_q))) pend_par <= 1'b1;
         if (stop_chk && !maj)                              pend_stop <= 1'b1;

         if (start_rej) Start_err <= 1'b1;

         // Strobes are registered on the way into DONE so they are visible during the DONE cycle.
         if (frame_end) begin
            if (pend_par || pend_stop || !maj) begin
               Parity_err <= pend_par;
               Stop_err   <= pend_stop | !maj;
            end else begin
               Data_Valid <= 1'b1;
               P_DATA     <= shift_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a frame-level model predicts every output
// cycle by cycle for an 8-bit and a 7-bit receiver driven side by side.
module tb_uart_rx_ctrl;

   localparam int N = 256;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       rx8, rx7;
   logic [5:0] Prescale;
   logic       Parity_En, Parity_Type, Stop_Bits;
   logic [7:0] p_data8;
   logic [6:0] p_data7;
   logic       dv8, perr8, serr8, sterr8, busy8;
   logic       dv7, perr7, serr7, sterr7, busy7;

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
      .Clk(Clk), .Rst(Rst), .Rx_in(rx8), .Prescale(Prescale),
      .Parity_En(Parity_En), .Parity_Type(Parity_Type), .Stop_Bits(Stop_Bits),
      .P_DATA(p_data8), .Data_Valid(dv8), .Parity_err(perr8), .Stop_err(serr8),
      .Start_err(sterr8), .Busy(busy8)
   );

   uart_rx_ctrl #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
      .Clk(Clk), .Rst(Rst), .Rx_in(rx7), .Prescale(Prescale),
      .Parity_En(Parity_En), .Parity_Type(Parity_Type), .Stop_Bits(Stop_Bits),
      .P_DATA(p_data7), .Data_Valid(dv7), .Parity_err(perr7), .Stop_err(serr7),
      .Start_err(sterr7), .Busy(busy7)
   );

   always #5 Clk = ~Clk;

   // Per-cycle line stimulus and expected outputs {busy, dv, perr, serr, sterr, data[8:0]}.
   logic        line_a [2][N];
   logic [5:0]  pres_a [N];
   logic [13:0] exp_a  [2][N];
   logic [8:0]  hold_pd [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit cmp_en   = 1'b0;
   int dv_first [2], dv_last [2], pe_first [2], se_first [2], st_first [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_scn(input logic [5:0] p);
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < N; c++) begin
            line_a[i][c] = 1'b1;
            exp_a[i][c]  = {5'b0, hold_pd[i]};
         end
         dv_first[i] = -1;
         dv_last[i]  = -1;
         pe_first[i] = -1;
         se_first[i] = -1;
         st_first[i] = -1;
      end
      for (int c = 0; c < N; c++) pres_a[c] = p;
   endtask

   // Line goes low at cycle s; the receiver's first START cycle is s+1.
   task automatic add_frame(input int inst, input int s, input int p, input logic [8:0] data,
                            input int dw, input bit pen, input bit ptype, input bit two,
                            input bit flip_par, input bit [1:0] bad_stop);
      bit         bits[$];
      logic [8:0] word;
      bit         par;
      int         f, d;
      bit         perr, serr;
      word = '0;
      par  = ptype;
      bits.push_back(1'b0);
      for (int i = 0; i < dw; i++) begin
         bits.push_back(data[i]);
         word[i] = data[i];
         par     = par ^ data[i];
      end
      if (pen) bits.push_back(par ^ flip_par);
      bits.push_back(!bad_stop[0]);
      if (two) bits.push_back(!bad_stop[1]);
      for (int k = 0; k < bits.size(); k++)
         for (int j = 0; j < p; j++) line_a[inst][s + k*p + j] = bits[k];
      f    = 1 + dw + int'(pen) + int'(two);
      d    = s + 1 + f*p + p/2 + 3;
      perr = pen && flip_par;
      serr = bad_stop[0] || (two && bad_stop[1]);
      for (int c = s + 1; c <= d; c++) exp_a[inst][c][13] = 1'b1;
      if (perr || serr) begin
         exp_a[inst][d][11] = perr;
         exp_a[inst][d][10] = serr;
      end else begin
         exp_a[inst][d][12] = 1'b1;
         for (int c = d; c < N; c++) exp_a[inst][c][8:0] = word;
         hold_pd[inst] = word;
      end
   endtask

   task automatic add_glitch(input int inst, input int s, input int len, input int p);
      for (int j = 0; j < len; j++) line_a[inst][s + j] = 1'b0;
      for (int c = s + 1; c <= s + p; c++) exp_a[inst][c][13] = 1'b1;
      exp_a[inst][s + 1 + p][9] = 1'b1;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge Clk);
         #1;
         cyc      = c;
         rx8      = line_a[0][c];
         rx7      = line_a[1][c];
         Prescale = pres_a[c];
         cmp_en   = 1'b1;
      end
      @(negedge Clk);
      #1 cmp_en = 1'b0;
   endtask

   always @(negedge Clk) begin
      if (cmp_en) begin
         check($sformatf("out8 {busy,dv,perr,serr,sterr,data} cyc %0d", cyc),
               {18'b0, busy8, dv8, perr8, serr8, sterr8, 1'b0, p_data8}, {18'b0, exp_a[0][cyc]});
         check($sformatf("out7 {busy,dv,perr,serr,sterr,data} cyc %0d", cyc),
               {18'b0, busy7, dv7, perr7, serr7, sterr7, 2'b0, p_data7}, {18'b0, exp_a[1][cyc]});
         if (dv8) begin
            if (dv_first[0] < 0) dv_first[0] = cyc;
            dv_last[0] = cyc;
         end
         if (dv7) begin
            if (dv_first[1] < 0) dv_first[1] = cyc;
            dv_last[1] = cyc;
         end
         if (perr8 && pe_first[0] < 0)  pe_first[0] = cyc;
         if (perr7 && pe_first[1] < 0)  pe_first[1] = cyc;
         if (serr8 && se_first[0] < 0)  se_first[0] = cyc;
         if (serr7 && se_first[1] < 0)  se_first[1] = cyc;
         if (sterr8 && st_first[0] < 0) st_first[0] = cyc;
         if (sterr7 && st_first[1] < 0) st_first[1] = cyc;
      end
   end

   initial begin
      Rst         = 1'b0;
      rx8         = 1'b1;
      rx7         = 1'b1;
      Prescale    = 6'd8;
      Parity_En   = 1'b0;
      Parity_Type = 1'b0;
      Stop_Bits   = 1'b0;
      hold_pd[0]  = '0;
      hold_pd[1]  = '0;

      #12;
      check("reset out8", {busy8, dv8, perr8, serr8, sterr8, p_data8}, 32'h0);
      check("reset out7", {busy7, dv7, perr7, serr7, sterr7, p_data7}, 32'h0);
      @(negedge Clk);
      Rst = 1'b1;

      // 8N1, P=8, 0xA5: Data_Valid 79 cycles after the first START cycle.
      clear_scn(6'd8);
      add_frame(0, 2, 8, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run(100);
      check("8N1 dv cycle", dv_first[0], 3 + 79);
      check("8N1 data", p_data8, 8'hA5);
      check("8N1 no stop err", se_first[0], -1);

      // 8E1, P=16, 0x3C with wrong parity: Parity_err only, data held.
      Parity_En = 1'b1;
      clear_scn(6'd16);
      add_frame(0, 2, 16, 9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      run(200);
      check("8E1 parity err cycle", pe_first[0], 3 + 171);
      check("8E1 no dv", dv_first[0], -1);
      check("8E1 data held", p_data8, 8'hA5);

      // 7O2, P=8, 0x55 with bad second stop bit, then a clean 0x2A.
      Parity_Type = 1'b1;
      Stop_Bits   = 1'b1;
      clear_scn(6'd8);
      add_frame(1, 2, 8, 9'h055, 7, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
      add_frame(1, 100, 8, 9'h02A, 7, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      run(220);
      check("7O2 stop err cycle", se_first[1], 3 + 87);
      check("7O2 no parity err", pe_first[1], -1);
      check("7O2 clean dv cycle", dv_first[1], 101 + 87);
      check("7O2 clean data", p_data7, 7'h2A);

      // Three-clock low glitch: Start_err at cycle P, then idle.
      Parity_En   = 1'b0;
      Parity_Type = 1'b0;
      Stop_Bits   = 1'b0;
      clear_scn(6'd8);
      add_glitch(0, 2, 3, 8);
      run(40);
      check("glitch start err cycle", st_first[0], 3 + 8);
      check("glitch busy low", busy8, 1'b0);
      check("glitch no dv", dv_first[0], -1);

      // Back-to-back 0x12 / 0xEF with Prescale changed to 10 mid-frame.
      clear_scn(6'd8);
      for (int c = 30; c < N; c++) pres_a[c] = 6'd10;
      add_frame(0, 2, 8, 9'h012, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add_frame(0, 82, 10, 9'h0EF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run(210);
      check("b2b first dv cycle", dv_first[0], 82);
      check("b2b second dv cycle", dv_last[0], 181);
      check("b2b second data", p_data8, 8'hEF);

      // Reset in the middle of DATA, then a clean 0x81.
      clear_scn(6'd8);
      add_frame(0, 2, 8, 9'h03F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run(40);
      check("busy before reset", busy8, 1'b1);
      Rst = 1'b0;
      rx8 = 1'b1;
      rx7 = 1'b1;
      #1;
      check("mid-frame reset out8", {busy8, dv8, perr8, serr8, sterr8, p_data8}, 32'h0);
      check("mid-frame reset out7", {busy7, dv7, perr7, serr7, sterr7, p_data7}, 32'h0);
      @(posedge Clk);
      @(negedge Clk);
      Rst        = 1'b1;
      hold_pd[0] = '0;
      hold_pd[1] = '0;
      clear_scn(6'd8);
      add_frame(0, 2, 8, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run(100);
      check("post-reset dv cycle", dv_first[0], 3 + 79);
      check("post-reset data", p_data8, 8'h81);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
